// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a framed byte stream into IMEM word writes.
// It holds the core in reset until a complete, checksum-verified image has been written.
module imem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  // N == 2^ADDR_WIDTH is legal, so the limit needs one bit beyond the count width.
  localparam logic [32:0] MAX_WORDS_C = 33'd1 << ADDR_WIDTH;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [31:0]         count_r;
  logic [31:0]         shift_r;
  logic [ADDR_WIDTH:0] word_idx_r;
  logic [7:0]          sum_r;
  logic [1:0]          byte_cnt_r;

  logic                byte_ready_r;
  logic                imem_we_r;
  logic [31:0]         imem_addr_r;
  logic [31:0]         imem_wdata_r;
  logic                core_rst_n_r;
  logic                busy_r;
  logic                done_r;
  logic                error_r;

  logic                xfer_s;
  logic                last_byte_s;
  logic                last_word_s;
  logic                restart_s;
  logic                active_next_s;
  logic [31:0]         hdr_count_s;
  logic [31:0]         assembled_s;
  logic [ADDR_WIDTH:0] word_idx_inc_s;

  assign xfer_s         = byte_valid && byte_ready_r;
  assign last_byte_s    = (byte_cnt_r == 2'd3);
  assign hdr_count_s    = {byte_data, count_r[31:8]};
  assign assembled_s    = {byte_data, shift_r[31:8]};
  assign word_idx_inc_s = word_idx_r + (ADDR_WIDTH + 1)'(1);
  assign last_word_s    = (32'(word_idx_inc_s) == count_r);
  assign active_next_s  = (state_next_s == ST_HDR) || (state_next_s == ST_DATA) ||
                          (state_next_s == ST_CSUM);

  // Next-state selection from the current state and the accepted byte.
  always_comb begin
    state_next_s = state_r;
    restart_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next_s = ST_HDR;
          restart_s    = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_HDR: begin
        if (xfer_s && last_byte_s) begin
          if ({1'b0, hdr_count_s} > MAX_WORDS_C) begin
            state_next_s = ST_ERROR;
          end else if (hdr_count_s == 32'd0) begin
            state_next_s = ST_CSUM;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_HDR;
        end
      end
      ST_DATA: begin
        if (xfer_s && last_byte_s && last_word_s) begin
          state_next_s = ST_CSUM;
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (xfer_s) begin
          if (byte_data == sum_r) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_ERROR;
          end
        end else begin
          state_next_s = ST_CSUM;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Header count, word assembly, running sum and the one-cycle IMEM write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r      <= 32'd0;
      shift_r      <= 32'd0;
      word_idx_r   <= '0;
      sum_r        <= 8'd0;
      byte_cnt_r   <= 2'd0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= 32'd0;
      imem_wdata_r <= 32'd0;
    end else begin
      imem_we_r <= 1'b0;
      if (restart_s) begin
        count_r    <= 32'd0;
        shift_r    <= 32'd0;
        word_idx_r <= '0;
        sum_r      <= 8'd0;
        byte_cnt_r <= 2'd0;
      end else if (xfer_s) begin
        byte_cnt_r <= byte_cnt_r + 2'd1;
        case (state_r)
          ST_HDR: begin
            count_r <= hdr_count_s;
          end
          ST_DATA: begin
            shift_r <= assembled_s;
            sum_r   <= csum_add(sum_r, byte_data);
            if (last_byte_s) begin
              imem_we_r    <= 1'b1;
              imem_addr_r  <= 32'({word_idx_r, 2'b00});
              imem_wdata_r <= assembled_s;
              word_idx_r   <= word_idx_inc_s;
            end
          end
          default: begin
            sum_r <= sum_r;
          end
        endcase
      end
    end
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      core_rst_n_r <= 1'b0;
    end else begin
      byte_ready_r <= active_next_s;
      busy_r       <= active_next_s;
      done_r       <= (state_next_s == ST_DONE);
      error_r      <= (state_next_s == ST_ERROR);
      core_rst_n_r <= (state_next_s == ST_DONE);
    end
  end

  assign byte_ready = byte_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign core_rst_n = core_rst_n_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random images against a queue-based frame model.
module tb_imem_loader;
  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, core_rst_n, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ready_drop = 0;
  bit          gapped = 1'b0;
  logic [31:0] img_q[$];
  logic [63:0] wr_q[$];
  int          wr_cyc_q[$];
  int          acc_cyc_q[$];

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_q.push_back({imem_addr, imem_wdata});
      wr_cyc_q.push_back(cyc);
    end
    if (busy === 1'b1 && byte_ready !== 1'b1) ready_drop++;
  end

  function automatic logic [7:0] model_csum();
    int s = 0;
    foreach (img_q[i]) for (int k = 0; k < 4; k++) s += int'((img_q[i] >> (8 * k)) & 32'hFF);
    return 8'(s % 256);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    while (gapped && $urandom_range(1, 0) == 1) begin
      byte_data = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = (byte_ready === 1'b1);
      tick();
      n++;
    end
    if (acc) acc_cyc_q.push_back(cyc);
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    n_vec++;
    if (!acc) begin
      n_err++;
      $display("FAIL handshake: byte %h not taken, ready low for %0d cycles (want taken)", b, n);
    end
  endtask

  task automatic load_frame(input logic [31:0] n_hdr, input logic [7:0] csum_delta,
                            input int start_at);
    logic [31:0] w;
    int bi = 0;
    wr_q.delete();
    wr_cyc_q.delete();
    acc_cyc_q.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(n_hdr[8*i +: 8]);
    if (n_hdr > 32'(1 << AW)) return;
    for (int j = 0; j < img_q.size(); j++) begin
      w = img_q[j];
      for (int i = 0; i < 4; i++) begin
        if (bi == start_at) start = 1'b1;
        send_byte(w[8*i +: 8]);
        start = 1'b0;
        bi++;
      end
    end
    send_byte(model_csum() + csum_delta);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'd0;
    tick(); tick();
    rst = 1'b0;
    n_vec++;
    if ({byte_ready, imem_we, busy, done, error, core_rst_n} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b want 000000",
               {byte_ready, imem_we, busy, done, error, core_rst_n});
    end
    n_vec++;
    if ({imem_addr, imem_wdata} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_bus: got %h want 0", {imem_addr, imem_wdata});
    end
    byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (3) tick();
    byte_valid = 1'b0;
    n_vec++;
    if ({byte_ready, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_no_accept: ready/busy got %b want 00", {byte_ready, busy});
    end
  endtask

  task automatic test_basic();
    gapped = 1'b0;
    img_q = '{32'h00500093, 32'h00A00113};
    load_frame(32'd2, 8'd0, -1);
    n_vec++;
    if ({done, core_rst_n, error, byte_ready, busy} !== 5'b11000) begin
      n_err++;
      $display("FAIL basic_done: done,rst_n,err,rdy,busy got %b want 11000",
               {done, core_rst_n, error, byte_ready, busy});
    end
    n_vec++;
    if (wr_q.size() != 2) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes want 2", wr_q.size());
    end else begin
      foreach (wr_q[i]) begin
        n_vec++;
        if (wr_q[i] !== {32'(i * 4), img_q[i]}) begin
          n_err++;
          $display("FAIL basic_write%0d: got %h want %h", i, wr_q[i], {32'(i * 4), img_q[i]});
        end
        n_vec++;
        if (wr_cyc_q[i] != acc_cyc_q[4 * i + 7]) begin
          n_err++;
          $display("FAIL basic_latency%0d: write in cycle %0d want %0d", i, wr_cyc_q[i],
                   acc_cyc_q[4 * i + 7]);
        end
      end
    end
  endtask

  task automatic test_bad_csum();
    gapped = 1'b0;
    img_q = '{32'h00500093, 32'h00A00113};
    load_frame(32'd2, 8'd1, -1);
    n_vec++;
    if ({error, done, core_rst_n, byte_ready} !== 4'b1000) begin
      n_err++;
      $display("FAIL bad_csum: err,done,rst_n,rdy got %b want 1000",
               {error, done, core_rst_n, byte_ready});
    end
    tick();
    n_vec++;
    if (core_rst_n !== 1'b0) begin
      n_err++;
      $display("FAIL bad_csum_hold: core_rst_n got %b want 0", core_rst_n);
    end
    wr_q.delete();
    pulse_start();
    n_vec++;
    if ({busy, byte_ready, error} !== 3'b110) begin
      n_err++;
      $display("FAIL restart_hdr: busy,rdy,err got %b want 110", {busy, byte_ready, error});
    end
    img_q.delete();
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    n_vec++;
    if ({done, core_rst_n, wr_q.size() == 0} !== 3'b111) begin
      n_err++;
      $display("FAIL empty_image: done,rst_n,nowrites got %b want 111",
               {done, core_rst_n, wr_q.size() == 0});
    end
  endtask

  task automatic test_oversize();
    logic [31:0] sizes[3] = '{32'd17, 32'h0000_0100, 32'hFFFF_FFFF};
    gapped = 1'b0;
    img_q.delete();
    foreach (sizes[k]) begin
      load_frame(sizes[k], 8'd0, -1);
      n_vec++;
      if ({error, busy, byte_ready, wr_q.size() == 0} !== 4'b1001) begin
        n_err++;
        $display("FAIL oversize_%h: err,busy,rdy,nowrites got %b want 1001", sizes[k],
                 {error, busy, byte_ready, wr_q.size() == 0});
      end
    end
  endtask

  task automatic test_full();
    gapped = 1'b0;
    img_q.delete();
    for (int i = 0; i < 16; i++) img_q.push_back($urandom);
    load_frame(32'd16, 8'd0, -1);
    n_vec++;
    if ({done, core_rst_n} !== 2'b11) begin
      n_err++;
      $display("FAIL full_done: done,rst_n got %b want 11", {done, core_rst_n});
    end
    n_vec++;
    if (wr_q.size() != 16) begin
      n_err++;
      $display("FAIL full_count: got %0d writes want 16", wr_q.size());
    end else begin
      foreach (wr_q[i]) begin
        n_vec++;
        if (wr_q[i] !== {32'(i * 4), img_q[i]}) begin
          n_err++;
          $display("FAIL full_write%0d: got %h want %h", i, wr_q[i], {32'(i * 4), img_q[i]});
        end
      end
      n_vec++;
      if (wr_q[15][63:32] !== 32'h3C) begin
        n_err++;
        $display("FAIL full_last_addr: got %h want 0000003c", wr_q[15][63:32]);
      end
    end
  endtask

  task automatic test_gapped();
    logic [63:0] ref_q[$];
    img_q.delete();
    for (int i = 0; i < 6; i++) img_q.push_back($urandom);
    gapped = 1'b0;
    load_frame(32'd6, 8'd0, -1);
    ref_q = wr_q;
    gapped = 1'b1;
    ready_drop = 0;
    load_frame(32'd6, 8'd0, -1);
    gapped = 1'b0;
    n_vec++;
    if ({done, ready_drop == 0} !== 2'b11) begin
      n_err++;
      $display("FAIL gapped_done: done got %b, ready drops %0d want 1 and 0", done, ready_drop);
    end
    n_vec++;
    if (wr_q.size() != 6 || ref_q.size() != 6) begin
      n_err++;
      $display("FAIL gapped_count: got %0d/%0d writes want 6/6", wr_q.size(), ref_q.size());
    end else begin
      foreach (wr_q[i]) begin
        n_vec++;
        if (wr_q[i] !== ref_q[i] || wr_q[i] !== {32'(i * 4), img_q[i]}) begin
          n_err++;
          $display("FAIL gapped_write%0d: got %h (b2b %h) want %h", i, wr_q[i], ref_q[i],
                   {32'(i * 4), img_q[i]});
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    gapped = 1'b0;
    img_q.delete();
    for (int i = 0; i < 3; i++) img_q.push_back($urandom);
    load_frame(32'd3, 8'd0, 5);
    n_vec++;
    if ({done, wr_q.size() == 3} !== 2'b11) begin
      n_err++;
      $display("FAIL start_ignored: done got %b, %0d writes want 1 and 3", done, wr_q.size());
    end else begin
      foreach (wr_q[i]) begin
        n_vec++;
        if (wr_q[i] !== {32'(i * 4), img_q[i]}) begin
          n_err++;
          $display("FAIL start_ignored_write%0d: got %h want %h", i, wr_q[i],
                   {32'(i * 4), img_q[i]});
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    gapped = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(i == 0 ? 8'd4 : 8'd0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_vec++;
    if ({byte_ready, imem_we, busy, done, error, core_rst_n, imem_addr, imem_wdata} !== 70'd0) begin
      n_err++;
      $display("FAIL midload_reset: flags %b bus %h want all 0",
               {byte_ready, imem_we, busy, done, error, core_rst_n}, {imem_addr, imem_wdata});
    end
    img_q = '{32'($urandom)};
    load_frame(32'd1, 8'd0, -1);
    n_vec++;
    if (done !== 1'b1 || wr_q.size() != 1) begin
      n_err++;
      $display("FAIL midload_reload: done %b writes %0d want 1 and 1", done, wr_q.size());
    end else begin
      n_vec++;
      if (wr_q[0] !== {32'd0, img_q[0]}) begin
        n_err++;
        $display("FAIL midload_first_write: got %h want %h", wr_q[0], {32'd0, img_q[0]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_oversize();
    test_full();
    test_gapped();
    test_start_ignored();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
